// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and op-code values.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SLTU = 4'd6;
  localparam logic [OP_W-1:0] OP_SLL  = 4'd7;
  localparam logic [OP_W-1:0] OP_SRL  = 4'd8;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd9;

  // Highest defined op code; anything above is illegal.
  localparam logic [OP_W-1:0] OP_MAX  = OP_SRA;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of decode-side, ALU-side and writeback-side signals of the issue stage.
interface alu_issue_stage_if #(
  parameter int XLEN   = alu_pkg::XLEN,
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int OP_W   = alu_pkg::OP_W
);
  logic              flush;
  // decode side
  logic              inValid;
  logic              inReady;
  logic [XLEN-1:0]   inRs1Data;
  logic [XLEN-1:0]   inRs2Data;
  logic [XLEN-1:0]   inImm;
  logic              inUseImm;
  logic [OP_W-1:0]   inOp;
  logic [REG_AW-1:0] inRd;
  logic              inRegWrite;
  // ALU side
  logic [XLEN-1:0]   aluOperandA;
  logic [XLEN-1:0]   aluOperandB;
  logic [OP_W-1:0]   aluOp;
  logic              aluEnable;
  logic [XLEN-1:0]   aluResult;
  logic              aluZero;
  // writeback side
  logic              outValid;
  logic              outReady;
  logic [XLEN-1:0]   outResult;
  logic              outZero;
  logic [REG_AW-1:0] outRd;
  logic              outRegWrite;
  logic              outIllegal;
  logic [31:0]       stallCount;

  // The issue stage itself.
  modport slave (
    input  flush, inValid, inRs1Data, inRs2Data, inImm, inUseImm, inOp, inRd, inRegWrite,
    output inReady,
    output aluOperandA, aluOperandB, aluOp, aluEnable,
    input  aluResult, aluZero,
    output outValid, outResult, outZero, outRd, outRegWrite, outIllegal, stallCount,
    input  outReady
  );

  // Surrounding pipeline: decode, ALU and writeback.
  modport master (
    output flush, inValid, inRs1Data, inRs2Data, inImm, inUseImm, inOp, inRd, inRegWrite,
    input  inReady,
    input  aluOperandA, aluOperandB, aluOp, aluEnable,
    output aluResult, aluZero,
    input  outValid, outResult, outZero, outRd, outRegWrite, outIllegal, stallCount,
    output outReady
  );
endinterface

// File: rtl/alu_result_queue.sv
// Two-entry valid/ready queue: an output register plus one skid entry.
// can_push_o depends only on the registered state, never on out_ready_i.
module alu_result_queue #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  output logic         can_push_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  typedef enum logic [1:0] {Q_EMPTY, Q_ONE, Q_TWO} q_state_e;

  q_state_e     state_q, state_d;
  logic [W-1:0] head_q, skid_q;
  logic         deq;

  assign deq        = (state_q != Q_EMPTY) && out_ready_i;
  assign out_data_o = head_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= Q_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: flush empties the queue ahead of any push or pop.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = Q_EMPTY;
    end else begin
      case (state_q)
        Q_EMPTY: if (push_i) state_d = Q_ONE;
        Q_ONE: begin
          if (push_i && !deq)      state_d = Q_TWO;
          else if (!push_i && deq) state_d = Q_EMPTY;
        end
        Q_TWO:   if (deq) state_d = Q_ONE;
        default: state_d = Q_EMPTY;
      endcase
    end
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    out_valid_o = (state_q != Q_EMPTY);
    can_push_o  = (state_q != Q_TWO);
  end

  // Entry storage: new data lands in the head unless the head is held, then in the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      case (state_q)
        Q_EMPTY: if (push_i) head_q <= push_data_i;
        Q_ONE: begin
          if (push_i && deq) head_q <= push_data_i;
          else if (push_i)   skid_q <= push_data_i;
        end
        Q_TWO:   if (deq) head_q <= skid_q;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage: operand select and ALU drive on accept, result queued toward writeback.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN   = alu_pkg::XLEN,
  parameter int REG_AW = alu_pkg::REG_AW,
  parameter int OP_W   = alu_pkg::OP_W
) (
  input logic             clk,
  input logic             reset,
  alu_issue_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0]   result;
    logic              zero;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              illegal;
  } entry_t;

  logic   ready_en_q;
  logic   can_push;
  logic   accept;
  logic   q_valid;
  entry_t entry_in, entry_out;

  // Hold inReady low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  assign bus.inReady = ready_en_q && can_push && !bus.flush;
  assign accept      = bus.inValid && bus.inReady;

  // Drive the ALU only for accepted instructions so idle cycles present zeros.
  always_comb begin
    bus.aluEnable   = accept;
    bus.aluOperandA = '0;
    bus.aluOperandB = '0;
    bus.aluOp       = '0;
    if (accept) begin
      bus.aluOperandA = bus.inRs1Data;
      bus.aluOperandB = bus.inUseImm ? bus.inImm : bus.inRs2Data;
      bus.aluOp       = bus.inOp;
    end
  end

  // Build the writeback entry; writes to x0 are suppressed here.
  always_comb begin
    entry_in.result    = bus.aluResult;
    entry_in.zero      = bus.aluZero;
    entry_in.rd        = bus.inRd;
    entry_in.reg_write = bus.inRegWrite && (bus.inRd != '0);
    entry_in.illegal   = (bus.inOp > OP_W'(OP_MAX));
  end

  alu_result_queue #(.W($bits(entry_t))) u_queue (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (bus.flush),
    .push_i      (accept),
    .push_data_i (entry_in),
    .can_push_o  (can_push),
    .out_valid_o (q_valid),
    .out_ready_i (bus.outReady),
    .out_data_o  (entry_out)
  );

  assign bus.outValid    = q_valid;
  assign bus.outResult   = entry_out.result;
  assign bus.outZero     = entry_out.zero;
  assign bus.outRd       = entry_out.rd;
  assign bus.outRegWrite = entry_out.reg_write;
  assign bus.outIllegal  = entry_out.illegal;

  // Saturating count of back-pressured cycles; flush does not clear it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bus.stallCount <= '0;
    else if (q_valid && !bus.outReady && (bus.stallCount != 32'hFFFF_FFFF))
      bus.stallCount <= bus.stallCount + 32'd1;
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vectors, corner sequences, random vs. model.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural ALU: illegal op codes and idle cycles return 0.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // ALU stub attached to the stage.
  always_comb begin
    logic [31:0] r;
    r = bus.aluEnable ? ref_alu(bus.aluOperandA, bus.aluOperandB, bus.aluOp) : 32'd0;
    bus.aluResult = r;
    bus.aluZero   = (r == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic use_imm,
                       input logic [4:0] rd, input logic rw);
    bus.inValid    = valid;
    bus.inOp       = op;
    bus.inRs1Data  = a;
    bus.inRs2Data  = b;
    bus.inImm      = imm;
    bus.inUseImm   = use_imm;
    bus.inRd       = rd;
    bus.inRegWrite = rw;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Reset for two cycles; release just after an edge so the next edge enables inReady.
  task automatic do_reset(input bit check_state);
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.outReady = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    if (check_state) begin
      chk("rst_inReady", bus.inReady, 0);
      chk("rst_outValid", bus.outValid, 0);
      chk("rst_outResult", bus.outResult, 0);
      chk("rst_stallCount", bus.stallCount, 0);
    end
    reset = 1'b1;
    #1;
    if (check_state) chk("rel_inReady_before_edge", bus.inReady, 0);
    tick();
    if (check_state) chk("rel_inReady_after_edge", bus.inReady, 1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, imm;
    logic        use_imm;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] exp_res;
    logic        exp_z, exp_rw, exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  vec_t vecs[10];
  exp_t mq[$];

  initial begin
    vecs[0] = '{OP_ADD,  32'd5,          32'd7,      32'd0,  1'b0, 5'd3,  1'b1, 32'd12,         1'b0, 1'b1, 1'b0};
    vecs[1] = '{OP_SUB,  32'd9,          32'd100,    32'd9,  1'b1, 5'd0,  1'b1, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'b1100, 32'd77,         32'd3,      32'd0,  1'b0, 5'd4,  1'b1, 32'd0,          1'b1, 1'b1, 1'b1};
    vecs[3] = '{OP_SLT,  32'hFFFF_FFFF,  32'd1,      32'd0,  1'b0, 5'd8,  1'b1, 32'd1,          1'b0, 1'b1, 1'b0};
    vecs[4] = '{OP_SLTU, 32'hFFFF_FFFF,  32'd1,      32'd0,  1'b0, 5'd9,  1'b0, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[5] = '{OP_SRA,  32'h8000_0000,  32'd4,      32'd0,  1'b0, 5'd10, 1'b1, 32'hF800_0000,  1'b0, 1'b1, 1'b0};
    vecs[6] = '{OP_SLL,  32'd1,          32'd0,      32'd31, 1'b1, 5'd11, 1'b1, 32'h8000_0000,  1'b0, 1'b1, 1'b0};
    vecs[7] = '{OP_XOR,  32'h0000_F0F0,  32'h0000_FF00, 32'd0, 1'b0, 5'd12, 1'b1, 32'h0000_0FF0, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{OP_AND,  32'hF0F0_F0F0,  32'd0,      32'h0F0F_0F0F, 1'b1, 5'd31, 1'b1, 32'd0,   1'b1, 1'b1, 1'b0};
    vecs[9] = '{OP_SRL,  32'h8000_0000,  32'd31,     32'd0,  1'b0, 5'd1,  1'b1, 32'd1,          1'b0, 1'b1, 1'b0};

    // ---- reset state ----
    do_reset(1'b1);

    // ---- directed table: one instruction at a time, writeback always ready ----
    bus.outReady = 1'b1;
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].use_imm, vecs[i].rd, vecs[i].rw);
      #1;
      chk($sformatf("vec%0d_aluEnable", i), bus.aluEnable, 1);
      chk($sformatf("vec%0d_aluOperandA", i), bus.aluOperandA, vecs[i].a);
      chk($sformatf("vec%0d_aluOperandB", i), bus.aluOperandB, vecs[i].use_imm ? vecs[i].imm : vecs[i].b);
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_aluEnable_idle", i), bus.aluEnable, 0);
      chk($sformatf("vec%0d_aluOperandA_idle", i), bus.aluOperandA, 0);
      chk($sformatf("vec%0d_outValid", i), bus.outValid, 1);
      chk($sformatf("vec%0d_outResult", i), bus.outResult, vecs[i].exp_res);
      chk($sformatf("vec%0d_outZero", i), bus.outZero, vecs[i].exp_z);
      chk($sformatf("vec%0d_outRd", i), bus.outRd, vecs[i].rd);
      chk($sformatf("vec%0d_outRegWrite", i), bus.outRegWrite, vecs[i].exp_rw);
      chk($sformatf("vec%0d_outIllegal", i), bus.outIllegal, vecs[i].exp_ill);
      tick();
      chk($sformatf("vec%0d_drained", i), bus.outValid, 0);
      $display("vec %0d op=%0d result=0x%0h", i, vecs[i].op, bus.outResult);
    end

    // ---- back-pressure: fill both entries, stall, drain in order ----
    do_reset(1'b0);
    drive(1'b1, OP_SUB, 32'd50, 32'd8, 32'd0, 1'b0, 5'd5, 1'b1);
    #1;
    chk("bp_i0_inReady", bus.inReady, 1);
    chk("bp_i0_aluEnable", bus.aluEnable, 1);
    tick();
    drive(1'b1, OP_XOR, 32'hFF, 32'h0F, 32'd0, 1'b0, 5'd6, 1'b1);
    #1;
    chk("bp_i1_inReady", bus.inReady, 1);
    chk("bp_i1_outResult", bus.outResult, 42);
    tick();
    drive(1'b1, OP_OR, 32'h100, 32'h1, 32'd0, 1'b0, 5'd7, 1'b1);
    #1;
    chk("bp_full_inReady", bus.inReady, 0);
    chk("bp_full_aluEnable", bus.aluEnable, 0);
    chk("bp_stall1", bus.stallCount, 1);
    tick();
    chk("bp_stall2", bus.stallCount, 2);
    chk("bp_hold_outResult", bus.outResult, 42);
    bus.outReady = 1'b1;
    #1;
    chk("bp_deq_cycle_aluEnable", bus.aluEnable, 0);
    tick();
    chk("bp_second_outResult", bus.outResult, 32'hF0);
    chk("bp_third_aluEnable", bus.aluEnable, 1);
    chk("bp_stall_frozen", bus.stallCount, 2);
    tick();
    idle();
    #1;
    chk("bp_third_outResult", bus.outResult, 32'h101);
    chk("bp_third_outRd", bus.outRd, 7);
    tick();
    chk("bp_empty", bus.outValid, 0);
    $display("backpressure sequence stallCount=%0d", bus.stallCount);

    // ---- flush while full ----
    do_reset(1'b0);
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd1, 1'b1);
    tick();
    drive(1'b1, OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 5'd2, 1'b1);
    tick();
    chk("fl_full_inReady", bus.inReady, 0);
    drive(1'b1, OP_ADD, 32'd100, 32'd200, 32'd0, 1'b0, 5'd3, 1'b1);
    bus.flush = 1'b1;
    bus.outReady = 1'b1;
    #1;
    chk("fl_aluEnable", bus.aluEnable, 0);
    chk("fl_inReady", bus.inReady, 0);
    chk("fl_head_seen", bus.outResult, 3);
    tick();
    bus.flush = 1'b0;
    bus.outReady = 1'b0;
    idle();
    #1;
    chk("fl_outValid", bus.outValid, 0);
    chk("fl_inReady_after", bus.inReady, 1);
    chk("fl_stallCount", bus.stallCount, 1);
    tick();
    chk("fl_still_empty", bus.outValid, 0);
    $display("flush sequence outValid=%0d", bus.outValid);

    // ---- async reset mid-operation ----
    do_reset(1'b0);
    drive(1'b1, OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 5'd9, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk("mr_outValid_before", bus.outValid, 1);
    chk("mr_stall_before", bus.stallCount, 2);
    #3;
    reset = 1'b0;
    #1;
    chk("mr_outValid_async", bus.outValid, 0);
    chk("mr_stall_async", bus.stallCount, 0);
    chk("mr_outResult_async", bus.outResult, 0);
    chk("mr_inReady_async", bus.inReady, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("mr_inReady_release", bus.inReady, 1);
    bus.outReady = 1'b1;
    drive(1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1);
    tick();
    idle();
    #1;
    chk("mr_slt_outValid", bus.outValid, 1);
    chk("mr_slt_outResult", bus.outResult, 1);
    tick();
    $display("reset sequence SLT result checked");

    // ---- random traffic against a queue model ----
    do_reset(1'b0);
    begin
      int unsigned sc_model = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
        logic        v, ui, rw, fl, ordy, m_ready, acc, deq;
        logic [3:0]  op;
        logic [31:0] a, b, imm, opb;
        logic [4:0]  rd;
        exp_t        e;
        v    = ($urandom_range(0, 3) != 0);
        op   = 4'($urandom_range(0, 15));
        a    = $urandom;
        b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
        imm  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        ui   = 1'($urandom_range(0, 1));
        rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        rw   = 1'($urandom_range(0, 1));
        ordy = ($urandom_range(0, 2) != 0);
        fl   = ($urandom_range(0, 15) == 0);
        drive(v, op, a, b, imm, ui, rd, rw);
        bus.outReady = ordy;
        bus.flush    = fl;
        #1;
        opb     = ui ? imm : b;
        m_ready = (mq.size() < 2) && !fl;
        acc     = v && m_ready;
        chk("rnd_inReady", bus.inReady, m_ready);
        chk("rnd_aluEnable", bus.aluEnable, acc);
        chk("rnd_outValid", bus.outValid, mq.size() > 0);
        chk("rnd_stallCount", bus.stallCount, sc_model);
        if (acc) begin
          chk("rnd_aluOperandB", bus.aluOperandB, opb);
          chk("rnd_aluOp", bus.aluOp, op);
        end
        if (mq.size() > 0) begin
          chk("rnd_outResult", bus.outResult, mq[0].result);
          chk("rnd_outZero", bus.outZero, mq[0].zero);
          chk("rnd_outRd", bus.outRd, mq[0].rd);
          chk("rnd_outRegWrite", bus.outRegWrite, mq[0].rw);
          chk("rnd_outIllegal", bus.outIllegal, mq[0].ill);
        end
        deq = (mq.size() > 0) && ordy;
        if ((mq.size() > 0) && !ordy && (sc_model != 32'hFFFF_FFFF)) sc_model++;
        if (fl) begin
          mq.delete();
        end else begin
          if (deq) void'(mq.pop_front());
          if (acc) begin
            e.result = ref_alu(a, opb, op);
            e.zero   = (e.result == 32'd0);
            e.rd     = rd;
            e.rw     = rw && (rd != 5'd0);
            e.ill    = (op > 4'd9);
            mq.push_back(e);
          end
        end
        @(posedge clk);
        #1;
      end
      $display("random phase done, model stallCount=%0d", sc_model);
    end

    bus.flush = 1'b0;
    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
